// File: rtl/vga_pkg.sv
// Shared VGA constants: screen geometry, 640x480 timing, frame-buffer widths, writer states.
package vga_pkg;

  localparam int unsigned H_RES    = 640;
  localparam int unsigned V_RES    = 480;

  // Horizontal timing, shared with the timing generator.
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_RES + H_FRONT + H_SYNC + H_BACK;  // 800

  // Vertical timing, shared with the timing generator.
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_RES + V_FRONT + V_SYNC + V_BACK;  // 525

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COLOUR_W = 12;
  localparam int unsigned COORD_W  = 10;
  // One extra bit so x0+w and y0+h cannot overflow.
  localparam int unsigned EXT_W    = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_e;

endpackage

// File: rtl/disp_rect_writer_if.sv
// Command handshake plus dispram port-A write bus of the rectangle writer.
interface disp_rect_writer_if;
  import vga_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [COORD_W-1:0]  cmd_x0;
  logic [COORD_W-1:0]  cmd_y0;
  logic [COORD_W-1:0]  cmd_w;
  logic [COORD_W-1:0]  cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [ADDR_W-1:0]   ramaddra;
  logic [COLOUR_W-1:0] ramdina;
  logic                ramwea;
  logic                busy;
  logic                done;

  // The writer itself.
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, ramaddra, ramdina, ramwea, busy, done
  );

  // The command source / observer.
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, ramaddra, ramdina, ramwea, busy, done
  );

endinterface

// File: rtl/rect_clip.sv
// Clips a rectangle to the visible screen: exclusive right/bottom edges and an empty flag.
module rect_clip
  import vga_pkg::*;
(
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_w,
  input  logic [COORD_W-1:0] i_h,
  output logic [EXT_W-1:0]   o_xe,
  output logic [EXT_W-1:0]   o_ye,
  output logic               o_empty
);

  localparam logic [EXT_W-1:0] HResExt = EXT_W'(H_RES);
  localparam logic [EXT_W-1:0] VResExt = EXT_W'(V_RES);

  logic [EXT_W-1:0] w_xsum;
  logic [EXT_W-1:0] w_ysum;

  // Saturate the far edges at the screen border; flag rectangles with nothing visible.
  always_comb begin
    w_xsum  = {1'b0, i_x0} + {1'b0, i_w};
    w_ysum  = {1'b0, i_y0} + {1'b0, i_h};
    o_xe    = (w_xsum > HResExt) ? HResExt : w_xsum;
    o_ye    = (w_ysum > VResExt) ? VResExt : w_ysum;
    o_empty = (i_w == '0) || (i_h == '0) ||
              ({1'b0, i_x0} >= HResExt) || ({1'b0, i_y0} >= VResExt);
  end

endmodule

// File: rtl/disp_rect_writer.sv
// Fills a clipped rectangle of the frame buffer with one colour, one pixel per clock.
module disp_rect_writer
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  disp_rect_writer_if.slave   io_bus
);

  state_e              r_state, w_state_d;
  logic [COORD_W-1:0]  r_x0, r_y0, r_w, r_h;
  logic [COLOUR_W-1:0] r_colour;
  logic [COORD_W-1:0]  r_x, w_x_d;
  logic [COORD_W-1:0]  r_y, w_y_d;
  logic [ADDR_W-1:0]   r_row_base, w_row_base_d;

  logic                r_cmd_ready, w_cmd_ready_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic                r_ramwea, w_ramwea_d;
  logic [ADDR_W-1:0]   r_ramaddra, w_ramaddra_d;
  logic [COLOUR_W-1:0] r_ramdina, w_ramdina_d;

  logic [EXT_W-1:0]    w_xe, w_ye;
  logic                w_empty;
  logic                w_accept;
  logic                w_last_col;
  logic                w_last_row;
  logic [ADDR_W-1:0]   w_base0;

  rect_clip u_clip (
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_xe    (w_xe),
    .o_ye    (w_ye),
    .o_empty (w_empty)
  );

  assign w_accept   = (r_state == IDLE) && io_bus.cmd_valid && r_cmd_ready;
  assign w_last_col = ({1'b0, r_x} == (w_xe - EXT_W'(1)));
  assign w_last_row = ({1'b0, r_y} == (w_ye - EXT_W'(1)));
  // y0*640 as two shifts; only used when y0 < V_RES, so it fits ADDR_W.
  assign w_base0    = ADDR_W'({r_y0, 9'd0}) + ADDR_W'({r_y0, 7'd0});

  // Latch the command on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_colour <= '0;
    end else if (w_accept) begin
      r_x0     <= io_bus.cmd_x0;
      r_y0     <= io_bus.cmd_y0;
      r_w      <= io_bus.cmd_w;
      r_h      <= io_bus.cmd_h;
      r_colour <= io_bus.cmd_colour;
    end
  end

  // State, walker position and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_row_base  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ramwea    <= 1'b0;
      r_ramaddra  <= '0;
      r_ramdina   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_x         <= w_x_d;
      r_y         <= w_y_d;
      r_row_base  <= w_row_base_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_ramwea    <= w_ramwea_d;
      r_ramaddra  <= w_ramaddra_d;
      r_ramdina   <= w_ramdina_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they align with it.
  always_comb begin
    w_state_d     = r_state;
    w_x_d         = r_x;
    w_y_d         = r_y;
    w_row_base_d  = r_row_base;
    w_cmd_ready_d = 1'b0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    w_ramwea_d    = 1'b0;
    w_ramaddra_d  = r_ramaddra;
    w_ramdina_d   = r_ramdina;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = SETUP;
          w_busy_d  = 1'b1;
        end else begin
          w_cmd_ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (w_empty) begin
          w_state_d = DONE;
          w_done_d  = 1'b1;
        end else begin
          w_state_d    = FILL;
          w_busy_d     = 1'b1;
          w_x_d        = r_x0;
          w_y_d        = r_y0;
          w_row_base_d = w_base0;
          w_ramwea_d   = 1'b1;
          w_ramaddra_d = w_base0 + ADDR_W'(r_x0);
          w_ramdina_d  = r_colour;
        end
      end
      FILL: begin
        // Outputs currently show pixel (r_x, r_y); prepare the following one.
        if (w_last_col && w_last_row) begin
          w_state_d = DONE;
          w_done_d  = 1'b1;
        end else begin
          w_busy_d   = 1'b1;
          w_ramwea_d = 1'b1;
          if (w_last_col) begin
            w_x_d        = r_x0;
            w_y_d        = r_y + COORD_W'(1);
            w_row_base_d = r_row_base + ADDR_W'(H_RES);
          end else begin
            w_x_d = r_x + COORD_W'(1);
          end
          w_ramaddra_d = w_row_base_d + ADDR_W'(w_x_d);
          w_ramdina_d  = r_colour;
        end
      end
      DONE: begin
        w_state_d     = IDLE;
        w_cmd_ready_d = 1'b1;
      end
      default: begin
        w_state_d     = IDLE;
        w_cmd_ready_d = 1'b1;
      end
    endcase
  end

  assign io_bus.cmd_ready = r_cmd_ready;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.ramwea    = r_ramwea;
  assign io_bus.ramaddra  = r_ramaddra;
  assign io_bus.ramdina   = r_ramdina;

endmodule

// File: tb/tb_disp_rect_writer.sv
// Self-checking bench for disp_rect_writer: directed corner cases plus random rectangles,
// every output compared cycle by cycle against a plain-arithmetic reference.
module tb_disp_rect_writer;
  import vga_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  disp_rect_writer_if bus ();

  disp_rect_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", tag, $time, got, got,
               exp, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"},  bus.busy,      0);
    chk({tag, "_done"},  bus.done,      0);
    chk({tag, "_wea"},   bus.ramwea,    0);
  endtask

  // Called at a negedge with the block idle. Issues one command and checks every cycle up to
  // and including the first idle cycle after done. hold keeps cmd_valid high afterwards.
  task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int col,
                         input bit hold);
    int xe, ye, cw, n, idx;
    bit empty;
    logic [31:0] ea;
    logic [11:0] ecol;
    xe    = (x0 + w > 640) ? 640 : x0 + w;
    ye    = (y0 + h > 480) ? 480 : y0 + h;
    empty = (w == 0) || (h == 0) || (x0 >= 640) || (y0 >= 480);
    cw    = xe - x0;
    n     = empty ? 0 : cw * (ye - y0);
    ecol  = col[11:0];
    chk("ready_pre", bus.cmd_ready, 1);
    bus.cmd_x0     = 10'(x0);
    bus.cmd_y0     = 10'(y0);
    bus.cmd_w      = 10'(w);
    bus.cmd_h      = 10'(h);
    bus.cmd_colour = ecol;
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) bus.cmd_valid = 1'b0;
      chk("ready_low", bus.cmd_ready, 0);
      chk("busy",      bus.busy,      32'(k <= n + 1));
      chk("done",      bus.done,      32'(k == n + 2));
      chk("wea",       bus.ramwea,    32'(k >= 2 && k <= n + 1));
      if (k >= 2 && k <= n + 1) begin
        idx = k - 2;
        ea  = 32'((y0 + idx / cw) * 640 + x0 + idx % cw);
        chk("addr", bus.ramaddra, ea);
        chk("data", bus.ramdina,  ecol);
      end
    end
    @(negedge clk);
    chk_idle("post");
  endtask

  int rx0, ry0, rw, rh;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_x0     = '0;
    bus.cmd_y0     = '0;
    bus.cmd_w      = '0;
    bus.cmd_h      = '0;
    bus.cmd_colour = '0;

    // Reset values.
    @(negedge clk);
    chk_idle("rst");
    chk("rst_addr", bus.ramaddra, 0);
    chk("rst_data", bus.ramdina,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rel");

    // Directed corners.
    run_cmd(0,   0,   2,   2, 12'hF00, 1'b0);
    run_cmd(638, 478, 5,   5, 12'h0F0, 1'b0);
    run_cmd(5,   5,   0,   3, 12'h123, 1'b0);
    run_cmd(5,   5,   3,   0, 12'h123, 1'b0);
    run_cmd(700, 5,   3,   3, 12'h456, 1'b0);
    run_cmd(0,   480, 2,   2, 12'h789, 1'b0);
    run_cmd(0,   479, 640, 1, 12'hFFF, 1'b0);
    run_cmd(639, 0,   1, 480, 12'hABC, 1'b0);
    run_cmd(600, 100, 1023, 3, 12'h00F, 1'b0);

    // Back-to-back with cmd_valid held: second accepted only once idle again.
    run_cmd(10,  20,  3,   2, 12'h111, 1'b1);
    run_cmd(630, 20,  20,  2, 12'h222, 1'b0);

    // Random rectangles, biased toward the screen edges half the time.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rx0 = $urandom_range(0, 639);
        ry0 = $urandom_range(0, 479);
      end else begin
        rx0 = $urandom_range(625, 660);
        ry0 = $urandom_range(470, 490);
      end
      rw = $urandom_range(0, 14);
      rh = $urandom_range(0, 5);
      run_cmd(rx0, ry0, rw, rh, int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a fill.
    bus.cmd_x0     = 10'd10;
    bus.cmd_y0     = 10'd10;
    bus.cmd_w      = 10'd20;
    bus.cmd_h      = 10'd20;
    bus.cmd_colour = 12'h5A5;
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_wea", bus.ramwea, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_addr", bus.ramaddra, 0);
    chk("async_rst_data", bus.ramdina,  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("abandon");
    end
    run_cmd(0, 0, 1, 1, 12'hABC, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
